// File: rtl/xgemac_pkg.sv
// Shared types and helpers for the xge_mac RX packet reader.
package xgemac_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned MOD_W  = 3;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [MOD_W-1:0]  mod;
        logic [DATA_W-1:0] data;
    } pkt_word_t;

    // Byte count carried by an eop word; mod of 0 means a full 8-byte word.
    function automatic logic [3:0] mod_bytes(input logic [MOD_W-1:0] mod);
        return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/xgemac_rx_skid_fifo.sv
// Small synchronous FIFO holding returned RX words ahead of the valid/ready stream.
module xgemac_rx_skid_fifo
    import xgemac_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  pkt_word_t     din,
    input  logic          pop,
    output pkt_word_t     dout,
    output logic [CW-1:0] count
);

    pkt_word_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/xgemac_pkt_rx_reader.sv
// Pops frames from the xge_mac RX interface, checks framing and forwards words on a valid/ready stream.
module xgemac_pkt_rx_reader
    import xgemac_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BYTES = 1518,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_rx_avail,
    output logic              pkt_rx_ren,
    input  logic              pkt_rx_val,
    input  logic              pkt_rx_sop,
    input  logic              pkt_rx_eop,
    input  logic [MOD_W-1:0]  pkt_rx_mod,
    input  logic              pkt_rx_err,
    input  logic [DATA_W-1:0] pkt_rx_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic              out_sop,
    output logic              out_eop,
    output logic [MOD_W-1:0]  out_mod,
    output logic [DATA_W-1:0] out_data,
    output logic              sts_val,
    output logic [LEN_W-1:0]  sts_len,
    output logic              sts_mac_err,
    output logic              sts_frm_err,
    output logic              sts_oversize,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned FCW = $clog2(DEPTH) + 1;
    localparam int unsigned CRW = FCW + 1;

    rx_state_e        state_q, state_d;
    logic             ren_q;
    logic             in_pkt_q, in_pkt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sts_val_q, sts_val_d;
    logic [LEN_W-1:0] sts_len_q, sts_len_d;
    logic             sts_mac_err_q, sts_mac_err_d;
    logic             sts_frm_err_q, sts_frm_err_d;
    logic             sts_oversize_q, sts_oversize_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             eop_rx;
    logic [FCW-1:0]   fifo_count;
    logic             fifo_push, fifo_pop;
    pkt_word_t        fifo_din, fifo_dout;

    logic [3:0]       word_bytes;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] new_len;
    logic             new_ovs;
    logic             trunc;
    logic             stray;
    logic             frame_inc;
    logic [1:0]       err_inc;
    logic [CNT_W:0]   err_sum;

    assign eop_rx = pkt_rx_val & pkt_rx_eop;

    // Credit: words already buffered, one in flight and the one requested now must all fit.
    assign pkt_rx_ren = (state_q == READ) & ~eop_rx
                      & ((CRW'(fifo_count) + CRW'(ren_q) + CRW'(1)) <= CRW'(DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pkt_rx_avail) state_d = READ;
            READ:    if (eop_rx)       state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Framing checker and status/counter update, evaluated per received word.
    always_comb begin
        in_pkt_d       = in_pkt_q;
        len_d          = len_q;
        sts_val_d      = 1'b0;
        sts_len_d      = '0;
        sts_mac_err_d  = 1'b0;
        sts_frm_err_d  = 1'b0;
        sts_oversize_d = 1'b0;
        fifo_push      = 1'b0;
        frame_inc      = 1'b0;
        err_inc        = 2'd0;

        word_bytes = pkt_rx_eop ? mod_bytes(pkt_rx_mod) : 4'd8;
        len_sum    = {1'b0, len_q} + (LEN_W + 1)'(word_bytes);
        new_len    = pkt_rx_sop ? LEN_W'(word_bytes)
                                : (len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0]);
        new_ovs    = new_len > LEN_W'(MAX_BYTES);
        trunc      = pkt_rx_val & pkt_rx_sop & in_pkt_q;
        stray      = pkt_rx_val & ~pkt_rx_sop & ~in_pkt_q;

        if (trunc) begin
            sts_val_d      = 1'b1;
            sts_len_d      = len_q;
            sts_frm_err_d  = 1'b1;
            sts_oversize_d = len_q > LEN_W'(MAX_BYTES);
            err_inc        = 2'd1;
        end

        if (stray) begin
            err_inc = 2'd1;
        end else if (pkt_rx_val) begin
            fifo_push = 1'b1;
            len_d     = new_len;
            in_pkt_d  = ~pkt_rx_eop;
            if (pkt_rx_eop) begin
                frame_inc = 1'b1;
                if (pkt_rx_err || new_ovs) begin
                    err_inc = err_inc + 2'd1;
                end
                // A single-word frame that truncates another still gets counted; the slot shows the truncation.
                if (!trunc) begin
                    sts_val_d      = 1'b1;
                    sts_len_d      = new_len;
                    sts_mac_err_d  = pkt_rx_err;
                    sts_oversize_d = new_ovs;
                end
            end
        end

        frame_cnt_d = (frame_inc && !(&frame_cnt_q)) ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
        err_sum     = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_inc);
        err_cnt_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ren_q          <= 1'b0;
            in_pkt_q       <= 1'b0;
            len_q          <= '0;
            sts_val_q      <= 1'b0;
            sts_len_q      <= '0;
            sts_mac_err_q  <= 1'b0;
            sts_frm_err_q  <= 1'b0;
            sts_oversize_q <= 1'b0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            ren_q          <= pkt_rx_ren;
            in_pkt_q       <= in_pkt_d;
            len_q          <= len_d;
            sts_val_q      <= sts_val_d;
            sts_len_q      <= sts_len_d;
            sts_mac_err_q  <= sts_mac_err_d;
            sts_frm_err_q  <= sts_frm_err_d;
            sts_oversize_q <= sts_oversize_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign fifo_din = '{sop: pkt_rx_sop, eop: pkt_rx_eop, mod: pkt_rx_mod, data: pkt_rx_data};
    assign fifo_pop = out_val & out_rdy;

    xgemac_rx_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // Stream fields are forced to zero while empty so stale storage never shows.
    assign out_val  = (fifo_count != '0);
    assign out_sop  = out_val & fifo_dout.sop;
    assign out_eop  = out_val & fifo_dout.eop;
    assign out_mod  = out_val ? fifo_dout.mod  : '0;
    assign out_data = out_val ? fifo_dout.data : '0;

    assign sts_val      = sts_val_q;
    assign sts_len      = sts_len_q;
    assign sts_mac_err  = sts_mac_err_q;
    assign sts_frm_err  = sts_frm_err_q;
    assign sts_oversize = sts_oversize_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_xgemac_pkt_rx_reader.sv
// Randomized bench for xgemac_pkt_rx_reader with a MAC read-side model and a frame-level scoreboard.
module tb_xgemac_pkt_rx_reader;
    import xgemac_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_BYTES = 1518;
    localparam int unsigned CNT_W     = 32;

    logic              clk;
    logic              rst;
    logic              pkt_rx_avail;
    logic              pkt_rx_ren;
    logic              pkt_rx_val;
    logic              pkt_rx_sop;
    logic              pkt_rx_eop;
    logic [2:0]        pkt_rx_mod;
    logic              pkt_rx_err;
    logic [63:0]       pkt_rx_data;
    logic              out_val;
    logic              out_rdy;
    logic              out_sop;
    logic              out_eop;
    logic [2:0]        out_mod;
    logic [63:0]       out_data;
    logic              sts_val;
    logic [15:0]       sts_len;
    logic              sts_mac_err;
    logic              sts_frm_err;
    logic              sts_oversize;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    xgemac_pkt_rx_reader #(
        .DEPTH     (DEPTH),
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_rx_avail (pkt_rx_avail),
        .pkt_rx_ren   (pkt_rx_ren),
        .pkt_rx_val   (pkt_rx_val),
        .pkt_rx_sop   (pkt_rx_sop),
        .pkt_rx_eop   (pkt_rx_eop),
        .pkt_rx_mod   (pkt_rx_mod),
        .pkt_rx_err   (pkt_rx_err),
        .pkt_rx_data  (pkt_rx_data),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_mod      (out_mod),
        .out_data     (out_data),
        .sts_val      (sts_val),
        .sts_len      (sts_len),
        .sts_mac_err  (sts_mac_err),
        .sts_frm_err  (sts_frm_err),
        .sts_oversize (sts_oversize),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        pkt_word_t w;
        logic      err;
        bit        mk_sts;
    } rx_ent_t;

    typedef struct packed {
        logic [15:0] len;
        logic        mac;
        logic        frm;
        logic        ovs;
    } sts_t;

    rx_ent_t   mac_q[$];
    rx_ent_t   raw_q[$];
    pkt_word_t exp_out_q[$];
    sts_t      exp_sts_q[$];
    int        sts_cyc_q[$];

    bit         m_in_pkt;
    int         m_len, m_frames, m_errs;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ren_cnt, n_rx, n_out, first_val_cyc, first_out_cyc, rdy_mode;
    bit         ren_pend, stall_prev;
    logic [69:0] prev_out;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: applies the framing rules to each word in arrival order.
    function automatic void model_word(input pkt_word_t w, input logic err, output bit mk_sts);
        int nb;
        nb     = (w.eop && w.mod != 3'd0) ? int'(w.mod) : 8;
        mk_sts = 1'b0;
        if (!w.sop && !m_in_pkt) begin
            m_errs++;
            return;
        end
        exp_out_q.push_back(w);
        if (w.sop && m_in_pkt) begin
            exp_sts_q.push_back('{len: 16'(m_len), mac: 1'b0, frm: 1'b1, ovs: (m_len > int'(MAX_BYTES))});
            m_errs++;
            mk_sts = 1'b1;
        end
        m_len    = w.sop ? nb : ((m_len + nb > 65535) ? 65535 : m_len + nb);
        m_in_pkt = !w.eop;
        if (w.eop) begin
            m_frames++;
            if (err || m_len > int'(MAX_BYTES)) m_errs++;
            if (!mk_sts) begin
                exp_sts_q.push_back('{len: 16'(m_len), mac: err, frm: 1'b0, ovs: (m_len > int'(MAX_BYTES))});
                mk_sts = 1'b1;
            end
        end
    endfunction

    task automatic add_word(input bit sop, input bit eop, input logic [2:0] mod, input logic err, input bit raw);
        rx_ent_t e;
        e.w.sop  = sop;
        e.w.eop  = eop;
        e.w.mod  = mod;
        e.w.data = {$urandom, $urandom};
        e.err    = err;
        model_word(e.w, err, e.mk_sts);
        if (raw) raw_q.push_back(e);
        else     mac_q.push_back(e);
    endtask

    task automatic add_frame(input int nbytes, input logic err);
        int nw;
        nw = (nbytes + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            add_word(i == 0, i == nw - 1, (i == nw - 1) ? 3'(nbytes % 8) : 3'd0,
                     err && (i == nw - 1), 1'b0);
        end
    endtask

    task automatic monitor();
        pkt_word_t x;
        sts_t      s;
        check("fifo_bound", 128'(dut.fifo_count > 3'(DEPTH)), 128'(0));
        if (stall_prev) begin
            check("out_hold", 128'({out_val, out_sop, out_eop, out_mod, out_data}), 128'(prev_out));
        end
        if (out_val && out_rdy) begin
            n_out++;
            if (exp_out_q.size() > 0) begin
                x = exp_out_q.pop_front();
                check("out_word", 128'({out_sop, out_eop, out_mod, out_data}), 128'(x));
            end else begin
                check("out_extra", 128'(out_val), 128'(0));
            end
        end
        if (out_val && first_out_cyc < 0) first_out_cyc = cyc;
        stall_prev = out_val & ~out_rdy;
        prev_out   = {out_val, out_sop, out_eop, out_mod, out_data};
        if (sts_val) begin
            if (exp_sts_q.size() > 0) begin
                s = exp_sts_q.pop_front();
                check("sts_word", 128'({sts_len, sts_mac_err, sts_frm_err, sts_oversize}), 128'(s));
                check("sts_cycle", 128'(cyc), 128'(sts_cyc_q.pop_front()));
            end else begin
                check("sts_extra", 128'(sts_val), 128'(0));
            end
        end
    endtask

    // One clock: drive MAC/raw words on the falling edge, sample just ahead of the rising edge.
    task automatic cycle();
        rx_ent_t e;
        bit      have;
        @(negedge clk);
        cyc++;
        e.w    = '0;
        e.err  = 1'b0;
        e.mk_sts = 1'b0;
        have   = 1'b0;
        if (raw_q.size() > 0) begin
            e = raw_q.pop_front();
            have = 1'b1;
        end else if (ren_pend && mac_q.size() > 0) begin
            e = mac_q.pop_front();
            have = 1'b1;
        end
        pkt_rx_val  = have;
        pkt_rx_sop  = e.w.sop;
        pkt_rx_eop  = e.w.eop;
        pkt_rx_mod  = e.w.mod;
        pkt_rx_err  = e.err;
        pkt_rx_data = e.w.data;
        if (have) begin
            n_rx++;
            if (first_val_cyc < 0) first_val_cyc = cyc;
            if (e.mk_sts) sts_cyc_q.push_back(cyc + 1);
        end
        pkt_rx_avail = (mac_q.size() > 0);
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = cyc[0];
            2:       out_rdy = 1'($urandom_range(0, 1));
            default: out_rdy = 1'b0;
        endcase
        #4;
        ren_pend = pkt_rx_ren & ~rst;
        if (pkt_rx_ren) ren_cnt++;
        if (!rst) monitor();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((mac_q.size() + raw_q.size() + exp_out_q.size() + exp_sts_q.size()) != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain_left", 128'(mac_q.size() + raw_q.size() + exp_out_q.size() + exp_sts_q.size()), 128'(0));
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mac_q.delete();
        raw_q.delete();
        exp_out_q.delete();
        exp_sts_q.delete();
        sts_cyc_q.delete();
        m_in_pkt = 1'b0;
        m_len = 0;
        m_frames = 0;
        m_errs = 0;
        ren_pend = 1'b0;
        stall_prev = 1'b0;
        ren_cnt = 0;
        n_rx = 0;
        n_out = 0;
        first_val_cyc = -1;
        first_out_cyc = -1;
        repeat (2) cycle();
        check("rst_out", 128'({pkt_rx_ren, out_val, out_sop, out_eop, out_mod, out_data}), 128'(0));
        check("rst_sts", 128'({sts_val, sts_len, sts_mac_err, sts_frm_err, sts_oversize, frame_cnt, err_cnt}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        pkt_rx_avail = 1'b0;
        pkt_rx_val = 1'b0;
        pkt_rx_sop = 1'b0;
        pkt_rx_eop = 1'b0;
        pkt_rx_mod = 3'd0;
        pkt_rx_err = 1'b0;
        pkt_rx_data = '0;
        out_rdy = 1'b0;
        rdy_mode = 0;

        // 64-byte frame, sink always ready
        do_reset();
        add_frame(64, 1'b0);
        drain(100);
        check("t1_ren_cycles", 128'(ren_cnt), 128'(8));
        check("t1_out_words", 128'(n_out), 128'(8));
        check("t1_latency", 128'(first_out_cyc - first_val_cyc), 128'(1));
        check("t1_frame_cnt", 128'(frame_cnt), 128'(1));
        check("t1_err_cnt", 128'(err_cnt), 128'(0));

        // 61-byte frame flagged bad by the MAC
        do_reset();
        add_frame(61, 1'b1);
        drain(100);
        check("t2_err_cnt", 128'(err_cnt), 128'(1));
        check("t2_frame_cnt", 128'(frame_cnt), 128'(1));

        // back-to-back 2-word frames, sink ready every other cycle
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) add_frame(int'($urandom_range(9, 16)), 1'b0);
        drain(400);
        check("t3_frame_cnt", 128'(frame_cnt), 128'(20));
        check("t3_err_cnt", 128'(err_cnt), 128'(0));
        check("t3_out_words", 128'(n_out), 128'(40));

        // frame truncated by a new sop
        do_reset();
        rdy_mode = 0;
        add_word(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add_word(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add_word(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add_word(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add_word(1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        drain(100);
        check("t4_err_cnt", 128'(err_cnt), 128'(1));

        // stray word outside a frame, then an oversize frame
        do_reset();
        add_word(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        repeat (3) cycle();
        check("t5_no_out", 128'(out_val), 128'(0));
        check("t5_stray_err", 128'(err_cnt), 128'(1));
        add_frame(1600, 1'b0);
        drain(600);
        check("t5_err_cnt", 128'(err_cnt), 128'(2));
        check("t5_frame_cnt", 128'(frame_cnt), 128'(1));

        // async reset after three words of a frame
        do_reset();
        rdy_mode = 3;
        add_frame(80, 1'b0);
        n = 0;
        while (n_rx < 3 && n < 50) begin
            cycle();
            n++;
        end
        check("t6_words_seen", 128'(n_rx >= 3), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out", 128'({pkt_rx_ren, out_val, out_sop, out_eop, out_mod, out_data}), 128'(0));
        check("t6_rst_sts", 128'({sts_val, sts_len, sts_mac_err, sts_frm_err, sts_oversize, frame_cnt, err_cnt}), 128'(0));
        do_reset();
        rdy_mode = 0;
        add_frame(64, 1'b0);
        drain(100);
        check("t6_frame_cnt", 128'(frame_cnt), 128'(1));
        check("t6_err_cnt", 128'(err_cnt), 128'(0));

        // random sizes, random MAC errors, random backpressure
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 15; i++) begin
            add_frame(int'($urandom_range(1, 200)), 1'($urandom_range(0, 3) == 0));
        end
        drain(2000);
        check("t7_frame_cnt", 128'(frame_cnt), 128'(m_frames));
        check("t7_err_cnt", 128'(err_cnt), 128'(m_errs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
